// File: rtl/math_unit_pkg.sv
// Shared definitions for the math datapath units: operation codes, FSM states
// and the default operand width.
package math_unit_pkg;

    localparam int DEFAULT_WIDTH = 512;

    localparam logic [1:0] OP_SUB  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_RSV2 = 2'b10;
    localparam logic [1:0] OP_RSV3 = 2'b11;

    typedef enum logic {
        IDLE,
        DIV
    } state_t;

endpackage

// File: rtl/math_inverse_unit_if.sv
// Operand/result bus of the inverse math unit with start/busy/done handshake.
interface math_inverse_unit_if
    import math_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [1:0]       operation;
    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] A2;
    logic [WIDTH-1:0] A3;
    logic [WIDTH-1:0] A4;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, operation, A1, A2,
        input  A3, A4, busy, done, div_by_zero
    );

    modport slave (
        input  start, operation, A1, A2,
        output A3, A4, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
    import math_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             quot_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           unused_msb;

    // Remainder after the step is always below the divisor, so the top bit is zero.
    assign shifted  = {rem_in, dividend_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign quot_bit = (shifted >= {1'b0, divisor});
    assign {unused_msb, rem_out} = quot_bit ? diff : shifted;
endmodule

// File: rtl/math_inverse_unit.sv
// Inverse companion of the add/multiply unit: single-cycle subtract and
// restoring unsigned division producing one quotient bit per clock.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | accepts start; subtract, divide-by-zero, reserved finish here
//   DIV   | one restoring step per cycle, counter counts WIDTH-1 down to 0
module math_inverse_unit
    import math_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    math_inverse_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   dq;        // dividend bits shift out the top, quotient bits fill the bottom
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   rem_next;
    logic               quot_bit;
    logic [CNT_W-1:0]   cnt;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (rem),
        .dividend_bit (dq[WIDTH-1]),
        .divisor      (divisor),
        .rem_out      (rem_next),
        .quot_bit     (quot_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            dq              <= '0;
            divisor         <= '0;
            rem             <= '0;
            cnt             <= '0;
            bus.A3          <= '0;
            bus.A4          <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.div_by_zero <= 1'b0;
                        case (bus.operation)
                            OP_SUB: begin
                                bus.A3   <= bus.A1 - bus.A2;
                                bus.A4   <= {{(WIDTH-1){1'b0}}, (bus.A1 < bus.A2)};
                                bus.done <= 1'b1;
                            end
                            OP_DIV: begin
                                if (bus.A2 == '0) begin
                                    bus.A3          <= '1;
                                    bus.A4          <= bus.A1;
                                    bus.div_by_zero <= 1'b1;
                                    bus.done        <= 1'b1;
                                end else begin
                                    dq       <= bus.A1;
                                    divisor  <= bus.A2;
                                    rem      <= '0;
                                    cnt      <= CNT_W'(WIDTH - 1);
                                    bus.busy <= 1'b1;
                                    state    <= DIV;
                                end
                            end
                            default: begin
                                bus.A3   <= '0;
                                bus.A4   <= '0;
                                bus.done <= 1'b1;
                            end
                        endcase
                    end
                end
                DIV: begin
                    dq  <= {dq[WIDTH-2:0], quot_bit};
                    rem <= rem_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        bus.A3   <= {dq[WIDTH-2:0], quot_bit};
                        bus.A4   <= rem_next;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_math_inverse_unit.sv
// Bench for math_inverse_unit at WIDTH 8, 16 and 512 against a cycle-level
// arithmetic model, plus literal expectations for the directed cases.
module tb_math_inverse_unit;
    import math_unit_pkg::*;

    typedef struct packed {
        logic [511:0] a3;
        logic [511:0] a4;
        logic [511:0] q;
        logic [511:0] r;
        logic [15:0]  cnt;
        logic         busy;
        logic         done;
        logic         dbz;
    } mstate_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   chk_en;
    mstate_t m8, m16, m512;

    math_inverse_unit_if #(.WIDTH(8))   if8 ();
    math_inverse_unit_if #(.WIDTH(16))  if16 ();
    math_inverse_unit_if #(.WIDTH(512)) if512 ();

    math_inverse_unit #(.WIDTH(8))   dut8   (.clk(clk), .rst_n(rst_n), .bus(if8));
    math_inverse_unit #(.WIDTH(16))  dut16  (.clk(clk), .rst_n(rst_n), .bus(if16));
    math_inverse_unit #(.WIDTH(512)) dut512 (.clk(clk), .rst_n(rst_n), .bus(if512));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: quotient/remainder come from / and %, latency is a plain count.
    function automatic mstate_t model_step(input mstate_t s, input logic rst, input logic start,
                                           input logic [1:0] op, input logic [511:0] a1,
                                           input logic [511:0] a2, input int w);
        mstate_t      n;
        logic [511:0] mask;
        mask   = {512{1'b1}} >> (512 - w);
        n      = s;
        n.done = 1'b0;
        if (!rst) begin
            n = '0;
        end else if (s.busy) begin
            n.cnt = s.cnt - 16'd1;
            if (n.cnt == 16'd0) begin
                n.busy = 1'b0;
                n.done = 1'b1;
                n.a3   = s.q;
                n.a4   = s.r;
            end
        end else if (start) begin
            n.dbz = 1'b0;
            if (op == OP_SUB) begin
                n.a3   = (a1 - a2) & mask;
                n.a4   = (a1 < a2) ? 512'd1 : 512'd0;
                n.done = 1'b1;
            end else if (op == OP_DIV && a2 == 512'd0) begin
                n.a3   = mask;
                n.a4   = a1;
                n.dbz  = 1'b1;
                n.done = 1'b1;
            end else if (op == OP_DIV) begin
                n.q    = a1 / a2;
                n.r    = a1 % a2;
                n.cnt  = 16'(w);
                n.busy = 1'b1;
            end else begin
                n.a3   = 512'd0;
                n.a4   = 512'd0;
                n.done = 1'b1;
            end
        end
        return n;
    endfunction

    initial begin
        m8 = '0;
        m16 = '0;
        m512 = '0;
    end

    always @(posedge clk) begin
        m8   <= model_step(m8,   rst_n, if8.start,   if8.operation,   512'(if8.A1),   512'(if8.A2),   8);
        m16  <= model_step(m16,  rst_n, if16.start,  if16.operation,  512'(if16.A1),  512'(if16.A2),  16);
        m512 <= model_step(m512, rst_n, if512.start, if512.operation, if512.A1,       if512.A2,       512);
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cmp(input string nm, input mstate_t m, input logic [511:0] a3,
                       input logic [511:0] a4, input logic b, input logic d, input logic z);
        chk({nm, ".A3"}, a3, m.a3);
        chk({nm, ".A4"}, a4, m.a4);
        chk({nm, ".busy"}, 512'(b), 512'(m.busy));
        chk({nm, ".done"}, 512'(d), 512'(m.done));
        chk({nm, ".dbz"}, 512'(z), 512'(m.dbz));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("w8",   m8,   512'(if8.A3),  512'(if8.A4),  if8.busy,  if8.done,  if8.div_by_zero);
            cmp("w16",  m16,  512'(if16.A3), 512'(if16.A4), if16.busy, if16.done, if16.div_by_zero);
            cmp("w512", m512, if512.A3,      if512.A4,      if512.busy, if512.done, if512.div_by_zero);
        end
    end

    task automatic go8(input logic [1:0] op, input logic [7:0] a1, input logic [7:0] a2);
        @(negedge clk);
        if8.start = 1'b1;
        if8.operation = op;
        if8.A1 = a1;
        if8.A2 = a2;
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic go512(input logic [511:0] a1, input logic [511:0] a2);
        @(negedge clk);
        if512.start = 1'b1;
        if512.operation = OP_DIV;
        if512.A1 = a1;
        if512.A2 = a2;
        @(negedge clk);
        if512.start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [15:0] a1, a2;
        logic [63:0] recon;
        bit          got;
        checks = 0;
        errors = 0;
        chk_en = 0;
        rst_n = 1'b0;
        if8.start = 0;   if8.operation = 0;   if8.A1 = 0;   if8.A2 = 0;
        if16.start = 0;  if16.operation = 0;  if16.A1 = 0;  if16.A2 = 0;
        if512.start = 0; if512.operation = 0; if512.A1 = 0; if512.A2 = 0;
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        chk("rst.A3", 512'(if8.A3), 512'd0);
        chk("rst.A4", 512'(if8.A4), 512'd0);
        chk("rst.flags", 512'({if8.busy, if8.done, if8.div_by_zero}), 512'd0);
        rst_n = 1'b1;

        go8(OP_SUB, 8'd5, 8'd7);
        chk("sub57.A3", 512'(if8.A3), 512'hFE);
        chk("sub57.A4", 512'(if8.A4), 512'h01);
        chk("sub57.done", 512'(if8.done), 512'd1);
        @(negedge clk);
        chk("sub57.done_pulse", 512'(if8.done), 512'd0);

        go8(OP_DIV, 8'd100, 8'd7);
        chk("div100.busy", 512'(if8.busy), 512'd1);
        repeat (7) @(negedge clk);
        chk("div100.not_yet", 512'(if8.done), 512'd0);
        @(negedge clk);
        chk("div100.done", 512'(if8.done), 512'd1);
        chk("div100.A3", 512'(if8.A3), 512'd14);
        chk("div100.A4", 512'(if8.A4), 512'd2);
        chk("div100.busy_end", 512'(if8.busy), 512'd0);

        go8(OP_DIV, 8'h3C, 8'd0);
        chk("dz.A3", 512'(if8.A3), 512'hFF);
        chk("dz.A4", 512'(if8.A4), 512'h3C);
        chk("dz.flag", 512'(if8.div_by_zero), 512'd1);
        go8(OP_SUB, 8'd1, 8'd1);
        chk("dz.cleared", 512'(if8.div_by_zero), 512'd0);

        @(negedge clk);
        if8.start = 1'b1; if8.operation = OP_DIV; if8.A1 = 8'd200; if8.A2 = 8'd3;
        @(negedge clk);
        if8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if8.start = 1'b1; if8.operation = OP_SUB; if8.A1 = 8'd9; if8.A2 = 8'd1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("div200.done", 512'(if8.done), 512'd1);
        chk("div200.A3", 512'(if8.A3), 512'd66);
        chk("div200.A4", 512'(if8.A4), 512'd2);

        go8(OP_DIV, 8'd200, 8'd3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst.A3", 512'(if8.A3), 512'd0);
        chk("midrst.A4", 512'(if8.A4), 512'd0);
        chk("midrst.busy", 512'(if8.busy), 512'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst.no_done", 512'(if8.done), 512'd0);

        go8(OP_SUB, 8'd9, 8'd4);
        chk("sub94.A3", 512'(if8.A3), 512'd5);
        go8(OP_RSV3, 8'd3, 8'd4);
        chk("rsv.A3", 512'(if8.A3), 512'd0);
        chk("rsv.done", 512'(if8.done), 512'd1);

        go512({512{1'b1}}, 512'd3);
        repeat (512) @(negedge clk);
        chk("w512.done", 512'(if512.done), 512'd1);
        chk("w512.A3", if512.A3, {128{4'h5}});
        chk("w512.A4", if512.A4, 512'd0);
        go512(512'd1 << 511, 512'd1 << 511);
        repeat (512) @(negedge clk);
        chk("w512b.A3", if512.A3, 512'd1);
        chk("w512b.A4", if512.A4, 512'd0);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = OP_SUB;
                4, 5, 6, 7: op = OP_DIV;
                8:          op = OP_RSV2;
                default:    op = OP_RSV3;
            endcase
            a1 = 16'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 5)) : 16'($urandom);
            @(negedge clk);
            if16.start = 1'b1;
            if16.operation = op;
            if16.A1 = a1;
            if16.A2 = a2;
            if (op == OP_DIV && a2 != 16'd0) begin
                got = 0;
                for (int k = 0; k < 24; k++) begin
                    @(negedge clk);
                    if (m16.done) begin
                        got = 1;
                        break;
                    end
                    if16.start = 1'($urandom_range(0, 1));
                    if16.operation = 2'($urandom);
                    if16.A1 = 16'($urandom);
                    if16.A2 = 16'($urandom);
                end
                if16.start = 1'b0;
                chk("rand.div_timeout", 512'(got), 512'd1);
                recon = 64'(if16.A3) * 64'(a2) + 64'(if16.A4);
                chk("rand.invariant", 512'(recon), 512'(a1));
                chk("rand.rem_lt", 512'(if16.A4 < a2), 512'd1);
            end
        end
        @(negedge clk);
        if16.start = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
